// File: rtl/baud_gen_os_pkg.sv
// baud_gen_os_pkg: shared constants and divisor clamp helper for the baud generator
package baud_gen_os_pkg;
    localparam int CLK_FREQ   = 1000000;
    localparam int BAUD       = 2400;
    localparam int OS         = 16;
    localparam int OS_W       = $clog2(OS);
    localparam int DIV_W_DEF  = 16;
    localparam int FRAC_W_DEF = 4;
    // Rounded clocks per os tick in 1/2^FRAC_W units: 16e6/38400 = 416.67 -> 417 = 26 + 1/16
    localparam int DIV_X      = (CLK_FREQ * (2 ** FRAC_W_DEF) + BAUD * OS / 2) / (BAUD * OS);
    localparam int DEF_INT    = DIV_X >> FRAC_W_DEF;
    localparam int DEF_FRAC   = DIV_X % (2 ** FRAC_W_DEF);

    function automatic logic [31:0] clamp_div(input logic [31:0] v);
        return (v < 32'd2) ? 32'd2 : v;
    endfunction
endpackage

// File: rtl/baud_gen_os_if.sv
// baud_gen_os_if: configuration and strobe bundle between the UART and the baud generator
interface baud_gen_os_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
);
    logic [DIV_W-1:0]  cfg_int;
    logic [FRAC_W-1:0] cfg_frac;
    logic              cfg_load;
    logic              tx_start;
    logic              rx_start;
    logic              tx_tick;
    logic              rx_sample;
    logic              rx_bit_end;
    logic              cfg_pending;
    logic              cfg_err;

    modport master (
        output cfg_int, cfg_frac, cfg_load, tx_start, rx_start,
        input  tx_tick, rx_sample, rx_bit_end, cfg_pending, cfg_err
    );
    modport slave (
        input  cfg_int, cfg_frac, cfg_load, tx_start, rx_start,
        output tx_tick, rx_sample, rx_bit_end, cfg_pending, cfg_err
    );
endinterface

// File: rtl/baud_gen_os_frac_div.sv
// baud_frac_div: fractional divider producing os ticks and an oversample phase count
module baud_frac_div
    import baud_gen_os_pkg::*;
#(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div_int,
    input  logic [FRAC_W-1:0] div_frac,
    output logic              os_tick,
    output logic [OS_W-1:0]   os_cnt
);
    logic [DIV_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   sum;
    logic [DIV_W:0]    last;

    // os_tick is the strobe that takes effect at the coming edge; os_cnt is the phase before it
    assign sum     = {1'b0, acc} + {1'b0, div_frac};
    assign last    = {1'b0, div_int} + (DIV_W+1)'(sum[FRAC_W]) - (DIV_W+1)'(1);
    assign os_tick = en && ({1'b0, cnt} == last);

    // Period counter, fractional accumulator and os phase; all cleared while disabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst || !en) begin
            cnt    <= '0;
            acc    <= '0;
            os_cnt <= '0;
        end else if (os_tick) begin
            cnt    <= '0;
            acc    <= sum[FRAC_W-1:0];
            os_cnt <= os_cnt + OS_W'(1);
        end else begin
            cnt    <= cnt + DIV_W'(1);
        end
    end
endmodule

// File: rtl/baud_gen_os.sv
// baud_gen_os: programmable fractional baud generator with independent TX and RX channels
module baud_gen_os
    import baud_gen_os_pkg::*;
#(
    parameter int DIV_W  = DIV_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input logic          clk,
    input logic          rst,
    baud_gen_os_if.slave bus
);
    logic [DIV_W-1:0]  div_int, pend_int, ld_int;
    logic [FRAC_W-1:0] div_frac, pend_frac, ld_frac;
    logic              pending, err, busy;
    logic              tx_os, rx_os;
    logic [OS_W-1:0]   tx_cnt, rx_cnt;
    logic              tx_tick_q, rx_sample_q, rx_end_q;

    // A freshly requested load takes priority over older pending values
    assign busy    = bus.tx_start | bus.rx_start;
    assign ld_int  = bus.cfg_load ? bus.cfg_int : pend_int;
    assign ld_frac = bus.cfg_load ? bus.cfg_frac : pend_frac;

    // Divisor is only swapped while both channels are idle so no frame sees a rate change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_int   <= DIV_W'(DEF_INT);
            div_frac  <= FRAC_W'(DEF_FRAC);
            pend_int  <= '0;
            pend_frac <= '0;
            pending   <= 1'b0;
            err       <= 1'b0;
        end else if (bus.cfg_load && busy) begin
            pend_int  <= bus.cfg_int;
            pend_frac <= bus.cfg_frac;
            pending   <= 1'b1;
        end else if (!busy && (bus.cfg_load || pending)) begin
            div_int   <= DIV_W'(clamp_div(32'(ld_int)));
            div_frac  <= ld_frac;
            err       <= ld_int < DIV_W'(2);
            pending   <= 1'b0;
        end
    end

    baud_frac_div #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_tx (
        .clk(clk), .rst(rst), .en(bus.tx_start), .div_int(div_int), .div_frac(div_frac),
        .os_tick(tx_os), .os_cnt(tx_cnt)
    );

    baud_frac_div #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_rx (
        .clk(clk), .rst(rst), .en(bus.rx_start), .div_int(div_int), .div_frac(div_frac),
        .os_tick(rx_os), .os_cnt(rx_cnt)
    );

    // Bit strobes registered on the same edge as the os tick that completes the phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_tick_q   <= 1'b0;
            rx_sample_q <= 1'b0;
            rx_end_q    <= 1'b0;
        end else begin
            tx_tick_q   <= tx_os && (tx_cnt == OS_W'(OS - 1));
            rx_sample_q <= rx_os && (rx_cnt == OS_W'(OS / 2 - 1));
            rx_end_q    <= rx_os && (rx_cnt == OS_W'(OS - 1));
        end
    end

    assign bus.tx_tick     = tx_tick_q;
    assign bus.rx_sample   = rx_sample_q;
    assign bus.rx_bit_end  = rx_end_q;
    assign bus.cfg_pending = pending;
    assign bus.cfg_err     = err;
endmodule
